seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative signed 32-bit divider for the multdiv unit. It is the counterpart to the Booth multiplier path: a start pulse launches one operation, and a ready pulse returns the result.
- The working state is a 65-bit {remainder, quotient} shift register, held in the existing register65 block.
- Non-restoring division on operand magnitudes, followed by a sign-fix cycle.
- Outputs feed the writeback mux in the same way as the multiplier result.

Parameters:
- WIDTH, 32, operand/result width; the working register is 2*WIDTH+1 bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- ctrl_div  input  1  start pulse; operands are sampled on the edge where it is 1.
- dividend  input  WIDTH  signed two's-complement dividend.
- divisor  input  WIDTH  signed two's-complement divisor.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; its sign follows the dividend.
- data_exception  output  1  divide-by-zero flag; valid while data_resultRDY is 1.
- data_resultRDY  output  1  one-cycle result-valid pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, working register=0.
  - quotient=0, remainder=0, data_exception=0, data_resultRDY=0, busy=0.
  - A reset mid-operation aborts the operation; no ready pulse is produced for it.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - ctrl_div=1 and divisor!=0 → BUSY.
  - On that edge: latch the sign bits; load working register = {(WIDTH+1)'b0, |dividend|}; load divisor magnitude; counter=0.
  - ctrl_div=1 and divisor==0 → DONE on the next edge, with quotient=0, remainder=dividend, data_exception=1.
- BUSY:
  - Each edge: shift the working register left by 1.
  - Add or subtract the divisor magnitude in the upper WIDTH+1 bits, depending on the sign of the partial remainder.
  - Set the quotient LSB to the inverted new sign.
  - counter++.
  - When counter reaches WIDTH-1 on an edge → FIX.
- FIX (one edge):
  - If the partial remainder is negative, add the divisor magnitude back.
  - Negate the quotient if the operand signs differed.
  - Negate the remainder if the dividend was negative.
  - Register the results into quotient/remainder → DONE.
- DONE:
  - data_resultRDY=1 for exactly this cycle; next edge → IDLE.
  - quotient, remainder and data_exception hold their values until the next completion or reset.
  - data_exception clears when the next operation starts.
- Latency: data_resultRDY is high in the cycle following edge WIDTH+1 counted after the start edge (WIDTH+2 edges total; 34 for WIDTH=32). Divide-by-zero takes 1 edge.
- Magnitudes use WIDTH+1 bits, so |−2^31| is represented without overflow.
- −2^31 / −1: quotient wraps to 0x80000000, remainder=0, data_exception=0.
- ctrl_div=1 during BUSY or FIX aborts the current operation and restarts with the new operands. The aborted operation produces no ready pulse.
- ctrl_div=1 in DONE: the ready pulse for the finishing operation still fires, and the new operation starts from that edge.
- busy=1 in BUSY and FIX; 0 in IDLE and DONE.

Decomposition:
- Shared multdiv package:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, FIX=2'd2, DONE=2'd3);
  - WIDTH default;
  - a two's-complement negate helper shared with the multiplier.
- Sub-module: the working register is one instance of register65 (clk, input_enable=1 in BUSY and at start, reset).
- The controller, adder/subtractor and sign fix stay in seq_divider.

Test Plan:
- dividend=100, divisor=7, ctrl_div pulse → after 34 edges data_resultRDY=1 for one cycle; quotient=14, remainder=2, data_exception=0.
- dividend=−100, divisor=7 → quotient=−14 (0xFFFFFFF2), remainder=−2. Then 100/−7 → quotient=−14, remainder=2.
- dividend=123, divisor=0 → data_resultRDY after 1 edge; data_exception=1, quotient=0, remainder=123. The next valid operation clears data_exception.
- dividend=0x80000000, divisor=0xFFFFFFFF → quotient=0x80000000, remainder=0, data_exception=0. Also 0x80000000/1 → quotient=0x80000000, remainder=0.
- Start 100/7, then at edge 10 pulse ctrl_div with 50/5 → exactly one ready pulse, 34 edges after the second start; quotient=10, remainder=0.
- Start 100/7, drop reset to 0 asynchronously at edge 15 (mid-cycle) → all outputs 0 immediately; release reset → IDLE and no spurious ready pulse. A fresh 9/2 then gives quotient=4, remainder=1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared multdiv definitions: divider FSM encoding, default widths, negate helper.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement negate; -2^(W-1) maps to itself.
  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
    return ~x + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/register65.sv
// Enable-gated working register holding {remainder, quotient}.
module register65 #(
  parameter int unsigned W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         input_enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable; asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (input_enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: non-restoring on magnitudes, then a sign-fix cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned PW = WIDTH + 1;
  localparam int unsigned RW = 2 * WIDTH + 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [PW-1:0]    dmag_q, dmag_d;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic             exc_d, rdy_d, busy_d;

  logic [RW-1:0]    work_q, work_d;
  logic             work_en;

  logic [PW-1:0]    part_r, shifted_r, step_r;
  logic [RW-1:0]    step_work;
  logic [WIDTH-1:0] quot_mag, rem_mag;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;

  register65 #(.W(RW)) u_work (
    .clk          (clk),
    .reset        (reset),
    .input_enable (work_en),
    .d            (work_d),
    .q            (work_q)
  );

  // Datapath: one non-restoring step, final correction, operand magnitudes.
  always_comb begin
    part_r    = work_q[RW-1:WIDTH];
    shifted_r = work_q[RW-2:WIDTH-1];
    step_r    = part_r[PW-1] ? (shifted_r + dmag_q) : (shifted_r - dmag_q);
    step_work = {step_r, work_q[WIDTH-2:0], ~step_r[PW-1]};
    quot_mag  = work_q[WIDTH-1:0];
    rem_mag   = part_r[PW-1] ? (part_r[WIDTH-1:0] + dmag_q[WIDTH-1:0]) : part_r[WIDTH-1:0];
    abs_dvd   = dividend[WIDTH-1] ? negate(dividend) : dividend;
    abs_dvs   = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
  end

  // Next-state and next-output logic; a start request overrides any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dmag_d  = dmag_q;
    quot_d  = quotient;
    rem_d   = remainder;
    exc_d   = data_exception;
    rdy_d   = 1'b0;
    work_en = 1'b0;
    work_d  = step_work;

    case (state_q)
      BUSY: begin
        work_en = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d  = q_neg_q ? negate(quot_mag) : quot_mag;
        rem_d   = r_neg_q ? negate(rem_mag) : rem_mag;
        exc_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (ctrl_div) begin
      cnt_d = '0;
      if (divisor == '0) begin
        work_en = 1'b0;
        quot_d  = '0;
        rem_d   = dividend;
        exc_d   = 1'b1;
        rdy_d   = 1'b1;
        state_d = DONE;
      end else begin
        work_en = 1'b1;
        work_d  = {{PW{1'b0}}, abs_dvd};
        dmag_d  = {1'b0, abs_dvs};
        q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg_d = dividend[WIDTH-1];
        quot_d  = quotient;
        rem_d   = remainder;
        exc_d   = 1'b0;
        rdy_d   = 1'b0;
        state_d = BUSY;
      end
    end

    busy_d = (state_d == BUSY) || (state_d == FIX);
  end

  // State, control and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      q_neg_q        <= 1'b0;
      r_neg_q        <= 1'b0;
      dmag_q         <= '0;
      quotient       <= '0;
      remainder      <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      q_neg_q        <= q_neg_d;
      r_neg_q        <= r_neg_d;
      dmag_q         <= dmag_d;
      quotient       <= quot_d;
      remainder      <= rem_d;
      data_exception <= exc_d;
      data_resultRDY <= rdy_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus abort/restart/reset sequences.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient, remainder;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  seq_divider dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .dividend       (dividend),
    .divisor        (divisor),
    .quotient       (quotient),
    .remainder      (remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    ctrl_div = 1'b1;
    @(posedge clk);
    #1;
    ctrl_div = 1'b0;
  endtask

  // Returns the edge count (start edge = 1) at which the ready pulse is seen.
  task automatic wait_ready(output int n);
    n = 1;
    while (!data_resultRDY && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_quotient"},  quotient, 32'h0);
    chk({tag, "_remainder"}, remainder, 32'h0);
    chk({tag, "_exc"},       32'(data_exception), 32'h0);
    chk({tag, "_rdy"},       32'(data_resultRDY), 32'h0);
    chk({tag, "_busy"},      32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = '{32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{-32'sd100,     32'd7,          -32'sd14,       -32'sd2,        1'b0, 34};
    vecs[2]  = '{32'd100,       -32'sd7,        -32'sd14,       32'd2,          1'b0, 34};
    vecs[3]  = '{-32'sd100,     -32'sd7,        32'd14,         -32'sd2,        1'b0, 34};
    vecs[4]  = '{32'd123,       32'd0,          32'd0,          32'd123,        1'b1, 1};
    vecs[5]  = '{32'd9,         32'd2,          32'd4,          32'd1,          1'b0, 34};
    vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34};
    vecs[7]  = '{32'h80000000,  32'd1,          32'h80000000,   32'd0,          1'b0, 34};
    vecs[8]  = '{32'd7,         32'd100,        32'd0,          32'd7,          1'b0, 34};
    vecs[9]  = '{32'h7FFFFFFF,  32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0, 34};
    vecs[10] = '{32'h80000000,  32'h80000000,   32'd1,          32'd0,          1'b0, 34};
    vecs[11] = '{32'h80000000,  32'd7,          32'hEDB6DB6E,   32'hFFFFFFFE,   1'b0, 34};
    vecs[12] = '{32'd0,         32'd5,          32'd0,          32'd0,          1'b0, 34};
    vecs[13] = '{-32'sd7,       32'd0,          32'd0,          -32'sd7,        1'b1, 1};

    // Reset state
    #2;
    chk_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].dvd, vecs[i].dvs);
      chk($sformatf("v%0d_busy", i), 32'(busy), (vecs[i].lat != 1) ? 32'd1 : 32'd0);
      wait_ready(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_exc", i), 32'(data_exception), 32'(vecs[i].exc));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rdy_drop", i), 32'(data_resultRDY), 32'd0);
    end

    // Restart mid-operation: only the second operation reports
    start_op(32'd100, 32'd7);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_rdy", 32'(data_resultRDY), 32'd0);
    end
    start_op(32'd50, 32'd5);
    wait_ready(n);
    chk("abort_latency", 32'(n), 32'd34);
    chk("abort_quotient", quotient, 32'd10);
    chk("abort_remainder", remainder, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_rdy_drop", 32'(data_resultRDY), 32'd0);

    // Start while in DONE: pulse already visible, new op launches from that edge
    start_op(32'd100, 32'd7);
    wait_ready(n);
    chk("done_start_first_q", quotient, 32'd14);
    dividend = 32'd50;
    divisor  = 32'd5;
    ctrl_div = 1'b1;
    @(posedge clk);
    #1;
    ctrl_div = 1'b0;
    chk("done_start_rdy_drop", 32'(data_resultRDY), 32'd0);
    chk("done_start_busy", 32'(busy), 32'd1);
    chk("done_start_q_hold", quotient, 32'd14);
    wait_ready(n);
    chk("done_start_latency", 32'(n), 32'd34);
    chk("done_start_quotient", quotient, 32'd10);
    chk("done_start_remainder", remainder, 32'd0);

    // Asynchronous reset mid-operation
    start_op(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      chk("post_reset_no_rdy", 32'(data_resultRDY), 32'd0);
    end
    start_op(32'd9, 32'd2);
    wait_ready(n);
    chk("post_reset_latency", 32'(n), 32'd34);
    chk("post_reset_quotient", quotient, 32'd4);
    chk("post_reset_remainder", remainder, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
